if_id_stage: RTL and testbench
==============================

# if_id_stage

Front-end stage holding the program counter and the IF/ID pipeline register of the 5-stage MIPS core. It consumes the load-use stall request from hazard detection, the data-cache miss stall, and the ID-stage branch redirect. Each cycle it either advances, holds, or injects a bubble into ID. It also keeps saturating stall/flush statistics and a sticky protocol-error flag.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset. Bits [1:0] must be 0.
- `CNT_W`, default 16: width of the performance counters.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-low.
- `hazard_stall_i`  in  1  load-use stall from hazard detection (its PCWrite/IFIDWrite output). 1 = hold PC and IF/ID.
- `mem_stall_i`  in  1  dcache miss stall. 1 = freeze the whole front end.
- `branch_i`  in  1  taken branch/jump resolved in ID.
- `branch_target_i`  in  32  redirect address.
- `imem_instr_i`  in  32  instruction memory read data for the current `pc_o` (combinational).
- `pc_o`  out  32  current fetch PC.
- `ifid_pc_o`  out  32  PC+4 of the instruction in IF/ID.
- `ifid_instr_o`  out  32  instruction in IF/ID.
- `ifid_valid_o`  out  1  IF/ID holds a real instruction (0 = bubble).
- `state_o`  out  2  FSM state, for debug.
- `hazard_err_o`  out  1  sticky protocol-error flag.
- `stall_cnt_o`  out  CNT_W  stall-cycle counter (performance counters only).
- `flush_cnt_o`  out  CNT_W  flush counter (performance counters only).

## Operation
- Per-edge priority when `rst_i`=1: mem_stall > hazard_stall > branch > advance.
- **MEM (`mem_stall_i`=1):**
  - PC and all IF/ID fields hold.
  - `branch_i` and `hazard_stall_i` are ignored; upstream keeps them stable.
- **HOLD (`hazard_stall_i`=1):**
  - PC and IF/ID hold.
  - `branch_i` is ignored, because the branch operands are not final yet.
- **FLUSH (`branch_i`=1):**
  - `pc_o` <= {branch_target_i[31:2],2'b00}.
  - `ifid_instr_o` <= 32'h0 (NOP), `ifid_pc_o` <= 0, `ifid_valid_o` <= 0.
- **Advance:**
  - `pc_o` <= `pc_o`+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
  - `ifid_instr_o` <= `imem_instr_i`, `ifid_pc_o` <= `pc_o`+4, `ifid_valid_o` <= 1.
- **FSM** (`state_o`): RUN=0, HOLD=1, MEM=2, FLUSH=3.
  - The next state is the class of the action taken this edge: advance -> RUN, hazard hold -> HOLD, mem hold -> MEM, redirect -> FLUSH.
  - FLUSH lasts exactly one cycle unless another event occurs.
- **Protocol check:**
  - `hazard_err_o` sets when `hazard_stall_i`=1 on an edge with `mem_stall_i`=0 while `state_o`==HOLD. A load-use stall is legally one cycle.
  - Once set, it clears only on reset.
  - MEM cycles between two hazard stalls do not count as consecutive: the state becomes MEM, so a later hazard stall is legal.
- **Reset values:**
  - `pc_o`=RESET_PC.
  - `ifid_pc_o`=0, `ifid_instr_o`=0, `ifid_valid_o`=0.
  - `state_o`=RUN, `hazard_err_o`=0, counters=0.
  - Reset mid-stall or mid-flush discards everything; the first fetch after reset is at RESET_PC.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Fetch-to-ID latency is 1 cycle: `imem_instr_i` sampled at edge N appears on `ifid_instr_o` after edge N.
- Redirect takes effect at the next edge. `pc_o`=target one cycle after `branch_i` is sampled. The bubble occupies ID for that cycle, and the target instruction reaches ID one cycle later.
- A hazard stall costs exactly 1 cycle. A mem stall costs as many cycles as `mem_stall_i` is high.
- Counters update on the same edge as the event they count and saturate at all-ones (no wrap).

## Configuration
- `IF_ID_PERF_CNT_EN` defined:
  - `stall_cnt_o` increments on every edge with `mem_stall_i`|`hazard_stall_i`.
  - `flush_cnt_o` increments on every FLUSH action (a branch ignored under a stall is not counted).
- Undefined:
  - Counter registers are not built.
  - `stall_cnt_o` and `flush_cnt_o` are tied to 0.
  - All other behaviour is identical.

## Test plan
- **Reset and advance:** `rst_i`=0 for 2 cycles, then 1 with RESET_PC=0x0 and imem returning 0x8C010004, 0x00221820 -> `pc_o` 0,4,8. IF/ID gets 0x8C010004 with `ifid_pc_o`=4, then 0x00221820 with `ifid_pc_o`=8. `ifid_valid_o`=1 from the first advance.
- **Load-use hold:** `hazard_stall_i`=1 for one cycle at `pc_o`=0x10 -> `pc_o` and IF/ID unchanged for 1 cycle, `state_o`=1, then advance to 0x14. With perf counters on, `stall_cnt_o`=1.
- **Redirect:** `branch_i`=1, target=0x40 at `pc_o`=0x20 -> next `pc_o`=0x40, `ifid_instr_o`=0, `ifid_valid_o`=0, `state_o`=3. The following cycle IF/ID holds the instruction from 0x40 with `ifid_pc_o`=0x44.
- **Simultaneous events:** `mem_stall_i`=1 for 3 cycles together with `hazard_stall_i` and `branch_i` -> no change for 3 cycles, `state_o`=2. With perf counters on, `stall_cnt_o`+=3 and `flush_cnt_o` unchanged. Then `branch_i` alone -> redirect.
- **Protocol error:** `hazard_stall_i`=1 on 2 consecutive non-mem cycles -> `hazard_err_o`=1 after the second edge and it stays 1 until `rst_i`=0. The sequence hazard, mem, hazard -> `hazard_err_o` stays 0.
- **Wrap and reset:** PC wraps 0xFFFF_FFFC -> 0x0000_0000 on advance. With perf counters on, preloading `stall_cnt_o` to 0xFFFF plus a stall keeps it at 0xFFFF. Asserting `rst_i`=0 during a mem stall -> all reset values on the next edge.

Source files
------------

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC register and IF/ID pipeline register of the 5-stage MIPS front end
// Saturating stall/flush counters are built only when IF_ID_PERF_CNT_EN is defined.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hazard_stall_i,
  input  logic             mem_stall_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_target_i,
  input  logic [31:0]      imem_instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      ifid_pc_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_valid_o,
  output logic [1:0]       state_o,
  output logic             hazard_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    MEM   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, ifid_pc_q, ifid_instr_q, pc_plus4;
  logic        ifid_valid_q, hazard_err_q, stalled, err_set;

  assign pc_plus4 = pc_q + 32'd4;

  // The next state is the action taken on this edge, resolved by priority.
  always_comb begin
    state_d = RUN;
    stalled = 1'b0;
    if (mem_stall_i) begin
      state_d = MEM;
      stalled = 1'b1;
    end else if (hazard_stall_i) begin
      state_d = HOLD;
      stalled = 1'b1;
    end else if (branch_i) begin
      state_d = FLUSH;
    end
  end

  // A second back-to-back load-use stall is illegal; a MEM cycle in between breaks the run.
  assign err_set = hazard_stall_i && !mem_stall_i && (state_q == HOLD);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_valid_q <= 1'b0;
      hazard_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set)
        hazard_err_q <= 1'b1;
      case (state_d)
        FLUSH: begin
          pc_q         <= {branch_target_i[31:2], 2'b00};
          ifid_pc_q    <= 32'h0;
          ifid_instr_q <= 32'h0;
          ifid_valid_q <= 1'b0;
        end
        RUN: begin
          pc_q         <= pc_plus4;
          ifid_pc_q    <= pc_plus4;
          ifid_instr_q <= imem_instr_i;
          ifid_valid_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stalled && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if ((state_d == FLUSH) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

  assign pc_o         = pc_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign state_o      = state_q;
  assign hazard_err_o = hazard_err_q;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage with a behavioural front-end model
// Counter expectations follow IF_ID_PERF_CNT_EN when it is defined.
module tb_if_id_stage;

  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef IF_ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0, h = 1'b0, m = 1'b0, b = 1'b0;
  logic [31:0]      tgt = 32'h0;
  logic [31:0]      imem;
  logic [31:0]      pc, ifpc, ifinstr;
  logic             ifvalid, err;
  logic [1:0]       st;
  logic [CNT_W-1:0] scnt, fcnt;

  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_valid, m_err;
  logic [1:0]  m_state;
  int          m_stall, m_flush;
  int          n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C01_0004;
    if (a == 32'h4) return 32'h0022_1820;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem = imem_f(pc);

  if_id_stage #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .hazard_stall_i(h), .mem_stall_i(m), .branch_i(b),
    .branch_target_i(tgt), .imem_instr_i(imem), .pc_o(pc), .ifid_pc_o(ifpc),
    .ifid_instr_o(ifinstr), .ifid_valid_o(ifvalid), .state_o(st), .hazard_err_o(err),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  // One clock: drive on the falling edge, update the model at the rising edge, settle 1ns.
  task automatic cyc(input logic hh, input logic mm, input logic bb, input logic [31:0] t, input logic r);
    @(negedge clk);
    h = hh; m = mm; b = bb; tgt = t; rst = r;
    @(posedge clk);
    if (!r) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_state = 2'd0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (hh && !mm && m_state == 2'd1) m_err = 1'b1;
      if (mm || hh) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (mm) m_state = 2'd2;
      else if (hh) m_state = 2'd1;
      else if (bb) begin
        m_pc = t & 32'hFFFF_FFFC; m_instr = 32'h0; m_ifpc = 32'h0; m_valid = 1'b0;
        m_state = 2'd3; m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      end else begin
        m_instr = imem_f(m_pc); m_ifpc = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        m_valid = 1'b1; m_state = 2'd0;
      end
    end
    #1;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b1, 1'b1, 32'h80, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
    n_cmp++; if (ifpc !== 32'h0 || ifinstr !== 32'h0 || ifvalid !== 1'b0) begin n_fail++; $display("FAIL rst_ifid: got %h %h %b want 0 0 0", ifpc, ifinstr, ifvalid); end
    n_cmp++; if (st !== 2'd0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_state: got %0d %b want 0 0", st, err); end
    n_cmp++; if (scnt !== '0 || fcnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %h %h want 0 0", scnt, fcnt); end
  endtask

  task automatic test_advance;
    adv(1);
    n_cmp++; if (pc !== 32'h4) begin n_fail++; $display("FAIL adv1_pc: got %h want %h", pc, 32'h4); end
    n_cmp++; if (ifinstr !== 32'h8C01_0004 || ifpc !== 32'h4 || ifvalid !== 1'b1) begin n_fail++; $display("FAIL adv1_ifid: got %h %h %b want 8c010004 4 1", ifinstr, ifpc, ifvalid); end
    adv(1);
    n_cmp++; if (pc !== 32'h8) begin n_fail++; $display("FAIL adv2_pc: got %h want %h", pc, 32'h8); end
    n_cmp++; if (ifinstr !== 32'h0022_1820 || ifpc !== 32'h8) begin n_fail++; $display("FAIL adv2_ifid: got %h %h want 00221820 8", ifinstr, ifpc); end
  endtask

  task automatic test_hold;
    adv(2);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (pc !== 32'h10 || st !== 2'd1) begin n_fail++; $display("FAIL hold_pc: got %h %0d want 10 1", pc, st); end
    n_cmp++; if (ifinstr !== imem_f(32'hC) || ifpc !== 32'h10) begin n_fail++; $display("FAIL hold_ifid: got %h %h want %h 10", ifinstr, ifpc, imem_f(32'hC)); end
    n_cmp++; if (scnt !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL hold_cnt: got %0d want %0d", scnt, PERF ? 1 : 0); end
    adv(1);
    n_cmp++; if (pc !== 32'h14 || st !== 2'd0 || ifinstr !== imem_f(32'h10)) begin n_fail++; $display("FAIL hold_resume: got %h %0d %h", pc, st, ifinstr); end
  endtask

  task automatic test_redirect;
    adv(3);
    cyc(1'b0, 1'b0, 1'b1, 32'h43, 1'b1);
    n_cmp++; if (pc !== 32'h40 || st !== 2'd3) begin n_fail++; $display("FAIL redir_pc: got %h %0d want 40 3", pc, st); end
    n_cmp++; if (ifinstr !== 32'h0 || ifpc !== 32'h0 || ifvalid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got %h %h %b want 0 0 0", ifinstr, ifpc, ifvalid); end
    n_cmp++; if (fcnt !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL redir_cnt: got %0d want %0d", fcnt, PERF ? 1 : 0); end
    adv(1);
    n_cmp++; if (ifinstr !== imem_f(32'h40) || ifpc !== 32'h44 || ifvalid !== 1'b1 || st !== 2'd0) begin n_fail++; $display("FAIL redir_target: got %h %h %b %0d", ifinstr, ifpc, ifvalid, st); end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
      n_cmp++; if (pc !== 32'h44 || st !== 2'd2 || ifinstr !== imem_f(32'h40) || ifpc !== 32'h44) begin n_fail++; $display("FAIL sim_hold%0d: got %h %0d %h %h", i, pc, st, ifinstr, ifpc); end
    end
    n_cmp++; if (scnt !== (PERF ? 16'd4 : 16'd0) || fcnt !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL sim_cnt: got %0d %0d", scnt, fcnt); end
    cyc(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    n_cmp++; if (pc !== 32'h100 || st !== 2'd3 || err !== 1'b0) begin n_fail++; $display("FAIL sim_redir: got %h %0d %b want 100 3 0", pc, st, err); end
  endtask

  task automatic test_protocol_error;
    adv(1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL perr_first: got %b want 0", err); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL perr_second: got %b want 1", err); end
    adv(2);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b want 1", err); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL perr_reset: got %b want 0", err); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (err !== 1'b0 || st !== 2'd1) begin n_fail++; $display("FAIL perr_mem_gap: got %b %0d want 0 1", err, st); end
  endtask

  task automatic test_wrap_and_reset;
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target: got %h want fffffffc", pc); end
    adv(1);
    n_cmp++; if (pc !== 32'h0 || ifpc !== 32'h0 || ifinstr !== imem_f(32'hFFFF_FFFC) || ifvalid !== 1'b1) begin n_fail++; $display("FAIL wrap_adv: got %h %h %h %b", pc, ifpc, ifinstr, ifvalid); end
    adv(2);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
    n_cmp++; if (pc !== 32'h0 || ifpc !== 32'h0 || ifinstr !== 32'h0 || ifvalid !== 1'b0 || st !== 2'd0 || err !== 1'b0 || scnt !== '0 || fcnt !== '0) begin n_fail++; $display("FAIL wrap_rst: got %h %h %h %b %0d %b %h %h", pc, ifpc, ifinstr, ifvalid, st, err, scnt, fcnt); end
    adv(1);
    n_cmp++; if (pc !== 32'h4 || ifinstr !== 32'h8C01_0004 || ifpc !== 32'h4) begin n_fail++; $display("FAIL wrap_refetch: got %h %h %h", pc, ifinstr, ifpc); end
`ifdef IF_ID_PERF_CNT_EN
    for (int i = 0; i < CMAX; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (scnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h want ffff", scnt); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (scnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", scnt); end
`endif
  endtask

  task automatic test_random;
    logic [CNT_W-1:0] es, ef;
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(5) == 0,
          $urandom, $urandom_range(49) != 0);
      es = PERF ? CNT_W'(m_stall) : '0;
      ef = PERF ? CNT_W'(m_flush) : '0;
      n_cmp++;
      if (pc !== m_pc || ifpc !== m_ifpc || ifinstr !== m_instr || ifvalid !== m_valid ||
          st !== m_state || err !== m_err || scnt !== es || fcnt !== ef) begin
        n_fail++;
        $display("FAIL rand%0d: got pc=%h ifpc=%h ins=%h v=%b st=%0d e=%b s=%h f=%h want pc=%h ifpc=%h ins=%h v=%b st=%0d e=%b s=%h f=%h",
                 i, pc, ifpc, ifinstr, ifvalid, st, err, scnt, fcnt,
                 m_pc, m_ifpc, m_instr, m_valid, m_state, m_err, es, ef);
      end
    end
  endtask

  initial begin
    test_reset;
    test_advance;
    test_hold;
    test_redirect;
    test_simultaneous;
    test_protocol_error;
    test_wrap_and_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
